// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared FSM state type and frame constants for the DAC SPI serializer.
package dac_spi_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    localparam logic [1:0] FRAME_PAD = 2'b00;
    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;
endpackage

// File: rtl/dac_sclk_divider.sv
// dac_sclk_divider: pulses tick every CLK_DIV cycles; clear restarts the half-period.
module dac_sclk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick  = cnt_q == CW'(CLK_DIV - 1);
    assign cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dac_spi_serializer.sv
// dac_spi_serializer: shifts each accepted sample out as one SYNC/SCLK/DIN frame.
// Define DAC_TWOS_COMP_EN to accept two's-complement samples (MSB inverted to offset binary).
module dac_spi_serializer
    import dac_spi_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int CLK_DIV  = 4,
    parameter int SYNC_GAP = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [1:0]        pd_mode,
    output logic              sclk,
    output logic              sync_n,
    output logic              sdin,
    output logic              busy
);
    localparam int FRAME_W = DATA_W + 4;
    localparam int CNT_W   = $clog2((FRAME_W > SYNC_GAP ? FRAME_W : SYNC_GAP) + 1);
    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sclk_q, sclk_d, sync_n_q, sync_n_d, busy_q, ready_q;
    logic               tick, accept;
    logic [DATA_W-1:0]  code;
`ifdef DAC_TWOS_COMP_EN
    assign code = {~data[DATA_W-1], data[DATA_W-2:0]};
`else
    assign code = data;
`endif
    assign accept = ready_q && data_valid;
    dac_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .Clk  (Clk),
        .Rst  (Rst),
        .clear(accept),
        .tick (tick)
    );
    // sdin is the shift register MSB; shifting on every rising sclk leaves it 0 after the last bit
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sclk_d   = sclk_q;
        sync_n_d = sync_n_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d  = SHIFT;
                shreg_d  = {FRAME_PAD, pd_mode, code};
                cnt_d    = '0;
                sclk_d   = 1'b1;
                sync_n_d = 1'b0;
            end
            SHIFT: if (tick) begin
                sclk_d = ~sclk_q;
                if (!sclk_q) begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q == CNT_W'(FRAME_W - 1) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                        state_d  = GAP;
                        sync_n_d = 1'b1;
                    end
                end
            end
            GAP: begin
                state_d = cnt_q == CNT_W'(SYNC_GAP - 1) ? IDLE : GAP;
                cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            sclk_q   <= 1'b1;
            sync_n_q <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            sclk_q   <= sclk_d;
            sync_n_q <= sync_n_d;
            busy_q   <= state_d != IDLE;
            ready_q  <= state_d == IDLE;
        end
    end
    assign sclk       = sclk_q;
    assign sync_n     = sync_n_q;
    assign sdin       = shreg_q[FRAME_W-1];
    assign busy       = busy_q;
    assign data_ready = ready_q;
endmodule

// File: tb/tb_dac_spi_serializer.sv
// tb_dac_spi_serializer: directed and random frames decoded from the SPI pins against an arithmetic frame model.
module tb_dac_spi_serializer;
    localparam int FRAME_W   = 16;
    localparam int CLK_DIV   = 4;
    localparam int SYNC_GAP  = 2;
    localparam int FRAME_CYC = 1 + 2 * FRAME_W * CLK_DIV;
    localparam int READY_CYC = FRAME_CYC + SYNC_GAP;
    logic        Clk = 1'b0, Rst = 1'b0, data_valid = 1'b0;
    logic [11:0] data = '0;
    logic [1:0]  pd_mode = '0;
    logic        data_ready, sclk, sync_n, sdin, busy;
    int          checks = 0, failures = 0;
    always #5 Clk = ~Clk;
    dac_spi_serializer dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .data      (data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .pd_mode   (pd_mode),
        .sclk      (sclk),
        .sync_n    (sync_n),
        .sdin      (sdin),
        .busy      (busy)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] model(input logic [11:0] d, input logic [1:0] pd);
        int code = int'(d);
`ifdef DAC_TWOS_COMP_EN
        code = (code + 2048) % 4096;
`endif
        return 32'(int'(pd) * 4096 + code);
    endfunction
    task automatic step();
        @(posedge Clk);
        #1;
    endtask
    task automatic send(input logic [11:0] d, input logic [1:0] pd, input bit hold,
                        input int chg_at, input int rst_at, input string tag);
        int          waited = 0, falls = 0, gap = 0;
        logic [15:0] got = '0;
        bit          tim_ok = 1'b1, sync_ok = 1'b1, ready_ok = 1'b1;
        logic        prev_sclk;
        data = d;
        pd_mode = pd;
        data_valid = 1'b1;
        while (!data_ready && waited < 1000) begin
            step();
            waited++;
        end
        chk({tag, " accept_wait"}, 32'(waited), 32'd0);
        step();
        if (!hold) data_valid = 1'b0;
        chk({tag, " c1_sync_sclk_busy_ready"}, 32'({sync_n, sclk, busy, data_ready}), 32'b0110);
        prev_sclk = sclk;
        for (int c = 1; c <= READY_CYC; c++) begin
            if (c == rst_at) begin
                Rst = 1'b0;
                #1;
                chk({tag, " rst_immediate"}, 32'({sync_n, sclk, data_ready, busy, sdin}), 32'b11000);
                repeat (2) step();
                chk({tag, " rst_held"}, 32'({sync_n, sclk, data_ready, busy}), 32'b1100);
                data_valid = 1'b0;
                Rst = 1'b1;
                step();
                chk({tag, " rst_release_ready"}, 32'({data_ready, sync_n, sclk}), 32'b111);
                return;
            end
            if (c == chg_at) data = 12'hFFF;
            if (prev_sclk && !sclk && !sync_n) begin
                falls++;
                got = {got[14:0], sdin};
                if (c != 1 + (2 * falls - 1) * CLK_DIV) tim_ok = 1'b0;
            end
            if (sync_n !== (c >= FRAME_CYC)) sync_ok = 1'b0;
            if (data_ready !== (c == READY_CYC)) ready_ok = 1'b0;
            if (sync_n && busy) gap++;
            prev_sclk = sclk;
            if (c < READY_CYC) step();
        end
        chk({tag, " falls"}, 32'(falls), 32'(FRAME_W));
        chk({tag, " frame"}, 32'(got), model(d, pd));
        chk({tag, " fall_timing"}, 32'(tim_ok), 32'd1);
        chk({tag, " sync_window"}, 32'(sync_ok), 32'd1);
        chk({tag, " ready_timing"}, 32'(ready_ok), 32'd1);
        chk({tag, " sync_gap"}, 32'(gap), 32'(SYNC_GAP));
        chk({tag, " end_busy_sclk"}, 32'({busy, sclk}), 32'b01);
    endtask
    initial begin
        int sclk_low = 0;
        data_valid = 1'b1;
        data = 12'h5A5;
        repeat (5) begin
            step();
            if (!sclk) sclk_low++;
        end
        chk("reset outputs", 32'({sync_n, sclk, data_ready, busy, sdin}), 32'b11000);
        chk("reset no_sclk_edge", 32'(sclk_low), 32'd0);
        data_valid = 1'b0;
        Rst = 1'b1;
        chk("reset release_ready_low", 32'(data_ready), 32'd0);
        step();
        chk("reset ready_after_1clk", 32'(data_ready), 32'd1);
        send(12'hA5C, 2'b00, 1'b0, 0, 0, "single");
        send(12'h000, 2'b00, 1'b1, 2, 0, "b2b_first");
        send(12'hFFF, 2'b00, 1'b0, 0, 0, "b2b_second");
        send(12'h123, 2'b11, 1'b0, 20, 0, "pd_hiz_midchg");
        send(12'(4095 - $urandom_range(0, 4094)), 2'b01, 1'b0, 0, 40, "abort");
        send(12'h7FF, 2'b00, 1'b0, 0, 0, "after_abort");
        send(12'h800, 2'b00, 1'b0, 0, 0, "code_800");
        send(12'h7FF, 2'b10, 1'b0, 0, 0, "code_7ff");
        send(12'h000, 2'b00, 1'b0, 0, 0, "code_000");
        for (int i = 0; i < 4; i++)
            send(12'($urandom_range(0, 4095)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(2, 120)), 0, "random");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
